// File: rtl/key_sched_pkg.sv
// rtl/key_sched_pkg.sv - shared types and timing constants for the key action scheduler
package key_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DEF_ON_CYC  = 30_000_000;
  localparam int DEF_GAP_CYC = 5_000_000;
  // 50 MHz system clock, also used by the per-key debounce blocks
  localparam int CYC_PER_MS  = 50_000;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module rr_pick #(
  parameter int N_KEY = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_KEY-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  logic [N_KEY-1:0] rot;
  int               pos;

  always_comb begin
    // rot[k] is the request of key (ptr + k) mod N_KEY
    rot   = N_KEY'({req, req} >> ptr);
    valid = |req;
    idx   = '0;
    pos   = 0;
    for (int k = N_KEY - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(ptr) + k;
        if (pos >= N_KEY) pos = pos - N_KEY;
        idx = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/key_action_sched.sv
// rtl/key_action_sched.sv - round-robin sharing of one timed action output among N keys
module key_action_sched
  import key_sched_pkg::*;
#(
  parameter int N_KEY   = 4,
  parameter int ID_W    = 2,
  parameter int ON_CYC  = DEF_ON_CYC,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int CNT_W   = 26
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [N_KEY-1:0] key_flag,
  input  logic             pend_clr,
  output logic             act_out,
  output logic [ID_W-1:0]  act_id,
  output logic             act_start,
  output logic             busy,
  output logic [N_KEY-1:0] pend,
  output logic             ovf
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [ID_W-1:0]  rr_ptr;
  logic             pick_valid;
  logic [ID_W-1:0]  pick_idx;
  logic             on_done;
  logic             gap_done;
  logic             grant;
  logic [N_KEY-1:0] grant_mask;

  rr_pick #(
    .N_KEY (N_KEY),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req   (pend),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign on_done    = (state == ST_ON)  && (timer == CNT_W'(ON_CYC - 1));
  assign gap_done   = (state == ST_GAP) && (timer == CNT_W'(GAP_CYC - 1));
  assign grant      = pick_valid && ((state == ST_IDLE) || gap_done);
  assign grant_mask = grant ? (N_KEY'(1) << pick_idx) : '0;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_IDLE;
    else            state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (grant)    state_next = ST_ON;
      ST_ON:   if (on_done)  state_next = ST_GAP;
      ST_GAP:  if (gap_done) state_next = grant ? ST_ON : ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    act_out = (state == ST_ON);
    busy    = (state != ST_IDLE);
  end

  // A new flag always wins over a grant-clear or pend_clr in the same cycle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      timer     <= '0;
      rr_ptr    <= '0;
      act_id    <= '0;
      act_start <= 1'b0;
      pend      <= '0;
      ovf       <= 1'b0;
    end else begin
      if (grant || on_done || gap_done) timer <= '0;
      else if (state != ST_IDLE)        timer <= timer + 1'b1;
      if (grant) begin
        act_id <= pick_idx;
        rr_ptr <= (pick_idx == ID_W'(N_KEY - 1)) ? '0 : pick_idx + 1'b1;
      end
      act_start <= grant;
      ovf       <= |(key_flag & pend & ~grant_mask);
      pend      <= (pend & ~grant_mask & ~{N_KEY{pend_clr}}) | key_flag;
    end
  end

endmodule

// File: tb/tb_key_action_sched.sv
// tb/tb_key_action_sched.sv - directed bench with a time-since-grant reference model
module tb_key_action_sched;

  localparam int N      = 4;
  localparam int ON     = 5;
  localparam int GAP    = 3;
  localparam int PERIOD = ON + GAP;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [3:0] key_flag = '0;
  logic       pend_clr = 1'b0;
  logic       act_out;
  logic [1:0] act_id;
  logic       act_start;
  logic       busy;
  logic [3:0] pend;
  logic       ovf;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cyc = 0;
  int st_id[$];
  int st_t[$];

  key_action_sched #(
    .N_KEY(N), .ID_W(2), .ON_CYC(ON), .GAP_CYC(GAP), .CNT_W(3)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag), .pend_clr(pend_clr),
    .act_out(act_out), .act_id(act_id), .act_start(act_start), .busy(busy),
    .pend(pend), .ovf(ovf)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
    end
  endtask

  // Reference model: m_d counts edges since the last grant; a grant may occur once a
  // whole ON+GAP period has elapsed (or at once when idle).
  logic [3:0] m_pend = '0;
  logic [3:0] m_gmask;
  int         m_ptr = 0;
  int         m_id = 0;
  int         m_d = PERIOD;
  int         m_pick;
  bit         m_start = 0;
  bit         m_ovf = 0;
  bit         m_grant;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_pend = '0; m_ptr = 0; m_id = 0; m_d = PERIOD; m_start = 0; m_ovf = 0;
    end else begin
      m_gmask = '0;
      m_grant = (m_pend != 0) && (m_d >= PERIOD - 1);
      if (m_grant) begin
        m_pick = -1;
        for (int k = 0; k < N; k++)
          if (m_pick < 0 && m_pend[(m_ptr + k) % N]) m_pick = (m_ptr + k) % N;
        m_gmask[m_pick] = 1'b1;
        m_id  = m_pick;
        m_ptr = (m_pick + 1) % N;
      end
      m_start = m_grant;
      m_ovf   = |(key_flag & m_pend & ~m_gmask);
      m_pend  = (m_pend & ~m_gmask & ~{4{pend_clr}}) | key_flag;
      m_d     = m_grant ? 0 : ((m_d < PERIOD) ? m_d + 1 : PERIOD);
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("model_act_out", act_out, m_d < ON);
      chk("model_busy", busy, m_d < PERIOD);
      chk("model_act_start", act_start, m_start);
      chk("model_act_id", act_id, m_id);
      chk("model_pend", pend, m_pend);
      chk("model_ovf", ovf, m_ovf);
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] f);
    key_flag = f;
    step();
    key_flag = '0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (act_start === 1'b1) begin
        st_id.push_back(int'(act_id));
        st_t.push_back(cyc);
      end
    end
  endtask

  task automatic do_reset();
    key_flag = '0;
    pend_clr = 1'b0;
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
    st_id.delete();
    st_t.delete();
  endtask

  int hi;

  initial begin
    do_reset();
    chk_en = 1;
    chk("rst_act_out", act_out, 0);
    chk("rst_act_id", act_id, 0);
    chk("rst_act_start", act_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovf", ovf, 0);

    // single request from idle
    pulse(4'b0100);
    chk("s1_pend_set", pend, 4'b0100);
    chk("s1_no_start_yet", act_start, 0);
    step();
    chk("s1_start", act_start, 1);
    chk("s1_id", act_id, 2);
    chk("s1_pend_clear", pend, 0);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      hi += int'(act_out);
      if (i == 7) chk("s1_busy_in_gap", busy, 1);
      step();
    end
    chk("s1_on_len", hi, 5);
    chk("s1_busy_done", busy, 0);
    chk("s1_act_id_hold", act_id, 2);

    // all four at once
    do_reset();
    pulse(4'b1111);
    run(40);
    chk("s2_n_starts", st_id.size(), 4);
    for (int k = 0; k < 4 && k < st_id.size(); k++) chk("s2_order", st_id[k], k);
    for (int k = 1; k < st_t.size(); k++) chk("s2_spacing", st_t[k] - st_t[k-1], PERIOD);

    // fairness against a key held every cycle
    do_reset();
    key_flag = 4'b1001;
    step();
    key_flag = 4'b0001;
    run(20);
    key_flag = '0;
    chk("s3_n_starts", st_id.size() >= 3, 1);
    if (st_id.size() >= 3) begin
      chk("s3_first", st_id[0], 0);
      chk("s3_second", st_id[1], 3);
      chk("s3_third", st_id[2], 0);
    end

    // duplicate request while pending
    do_reset();
    pulse(4'b0001);
    step();
    pulse(4'b0010);
    chk("s4_ovf_first", ovf, 0);
    pulse(4'b0010);
    chk("s4_ovf_second", ovf, 1);
    chk("s4_pend_merged", pend, 4'b0010);
    st_id.delete();
    run(30);
    chk("s4_served_once", st_id.size(), 1);
    if (st_id.size() >= 1) chk("s4_served_id", st_id[0], 1);

    // flag on the grant cycle of the same key
    do_reset();
    key_flag = 4'b0010;
    step();
    step();
    key_flag = '0;
    chk("s4b_start", act_start, 1);
    chk("s4b_id", act_id, 1);
    chk("s4b_pend_kept", pend, 4'b0010);
    chk("s4b_no_ovf", ovf, 0);
    run(20);
    chk("s4b_served_again", st_id.size(), 1);

    // pend_clr during ON
    do_reset();
    pulse(4'b0001);
    step();
    pulse(4'b1010);
    chk("s5_pend_loaded", pend, 4'b1010);
    pend_clr = 1'b1;
    step();
    pend_clr = 1'b0;
    chk("s5_pend_cleared", pend, 0);
    chk("s5_window_kept", act_out, 1);
    run(16);
    chk("s5_no_more_starts", st_id.size(), 0);
    chk("s5_idle", busy, 0);
    do_reset();
    pulse(4'b0001);
    step();
    pulse(4'b1010);
    key_flag = 4'b0001;
    pend_clr = 1'b1;
    step();
    key_flag = '0;
    pend_clr = 1'b0;
    chk("s5_clr_with_flag", pend, 4'b0001);

    // asynchronous reset mid-ON
    do_reset();
    pulse(4'b0100);
    step();
    pulse(4'b1000);
    step();
    sys_rst_n = 1'b0;
    #1;
    chk("s6_act_out", act_out, 0);
    chk("s6_busy", busy, 0);
    chk("s6_pend", pend, 0);
    chk("s6_act_id", act_id, 0);
    chk("s6_act_start", act_start, 0);
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("s6_stay_idle", busy, 0);
    end
    pulse(4'b0010);
    step();
    chk("s6_restart", act_start, 1);
    chk("s6_restart_id", act_id, 1);
    run(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/key_action_sched.md
# key_action_sched

Round-robin scheduler that shares one timed action output (buzzer/LED drive) among N debounced keys. Each key's debouncer feeds a one-cycle `key_flag` pulse into the block. The block latches each pulse as a pending request. It grants one request at a time and drives `act_out` high for a fixed ON window, then holds a mandatory GAP window before the next grant. It sits between the per-key debounce blocks and the single shared indicator pin.

## Interface
- `N_KEY`, default 4: number of requesting keys, 2..8.
- `ID_W`, default 2: width of the key index. Must satisfy 2^ID_W >= N_KEY.
- `ON_CYC`, default 30_000_000: `act_out` high time in sys_clk cycles, >= 1.
- `GAP_CYC`, default 5_000_000: forced low time after each action, >= 1.
- `CNT_W`, default 26: timer width. Must hold max(ON_CYC, GAP_CYC) - 1.

Ports:
- `sys_clk` in 1: clock.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `key_flag` in N_KEY: one-cycle request pulses, bit i = key i.
- `pend_clr` in 1: synchronous clear of all pending requests.
- `act_out` out 1: shared action drive. Reset 0.
- `act_id` out ID_W: index of the key currently/last granted. Reset 0.
- `act_start` out 1: one-cycle pulse on the first cycle of each ON window. Reset 0.
- `busy` out 1: high in ON or GAP. Reset 0.
- `pend` out N_KEY: registered pending vector. Reset 0.
- `ovf` out 1: one-cycle pulse when `key_flag[i]` arrives while `pend[i]` is already 1 and not being granted that cycle. Reset 0.

## Operation
- States: IDLE, ON, GAP. Reset state is IDLE, timer 0, round-robin pointer `rr_ptr` = 0.
- Pending update, per bit: next = (`pend` & ~grant_mask & ~{N{`pend_clr`}}) | `key_flag`. A new flag always wins over a grant-clear or `pend_clr` in the same cycle.
- Pick: the first set bit of `pend` searching `rr_ptr`, `rr_ptr`+1, … modulo N_KEY.
- IDLE → ON when `pend` != 0:
  - the picked bit is cleared;
  - `act_id` <= index;
  - `rr_ptr` <= (index+1) mod N_KEY;
  - `act_start` pulses;
  - timer <= 0.
- ON: `act_out` = 1. The timer counts 0..ON_CYC-1. At ON_CYC-1, go to GAP and set timer <= 0.
- GAP: `act_out` = 0. The timer counts 0..GAP_CYC-1. At GAP_CYC-1:
  - if `pend` != 0, go directly to ON with a new pick, same actions as IDLE → ON;
  - otherwise go to IDLE.
- `pend_clr` never aborts an ON or GAP window in progress.
- `ovf` does not change `pend`; the duplicate request is simply merged.
- Asynchronous reset mid-ON/GAP: all outputs return to their reset values immediately and all pending requests are lost.

## Timing
- `key_flag[i]` sampled at edge t sets `pend[i]` visible after t.
- If the block is IDLE, the grant occurs at edge t+1. `act_out` and `act_start` are high after t+1. Flag-to-drive latency is 2 cycles.
- `act_out` is high for exactly ON_CYC cycles and low for at least GAP_CYC cycles between actions.
- Back-to-back actions: the period is exactly ON_CYC + GAP_CYC cycles.
- All outputs are registered. There is no combinational path from `key_flag` to any output.
- `act_id` holds its value through GAP and IDLE until the next grant.

## Structure
- Package `key_sched_pkg`:
  - state enum (IDLE/ON/GAP);
  - default ON_CYC/GAP_CYC constants;
  - the 50 MHz cycles-per-ms constant shared with the debounce blocks.
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `req`[N_KEY], `ptr`[ID_W].
  - Outputs: `valid`, `idx`[ID_W].
  - Instantiated once; the FSM, timer and pend register live in the top.

## Test plan
All scenarios use N_KEY=4, ON_CYC=5, GAP_CYC=3.
1. Pulse `key_flag`=4'b0100 once from IDLE:
   - `act_start` 2 cycles later;
   - `act_id`=2;
   - `act_out` high for exactly 5 cycles;
   - `busy` low 8 cycles after the start;
   - `pend` back to 0.
2. Pulse `key_flag`=4'b1111 in one cycle:
   - grants in order 0,1,2,3;
   - `act_start` spacing is exactly 8 cycles;
   - `act_out` is never high for two adjacent windows without a 3-cycle low gap.
3. Fairness: hold key0 pulsing every cycle while key3 requests once. Key3 must be granted immediately after the first key0 action, not starved.
4. Overflow and same-cycle collision:
   - during ON, pulse `key_flag[1]` twice: `ovf`=1 on the second pulse, and key1 is served once;
   - assert `key_flag[1]` on the cycle key1 is granted: `pend[1]` remains 1 and key1 is served again.
5. `pend_clr` during ON with `pend`=4'b1010: the current window completes, then the block returns to IDLE. `pend_clr` together with `key_flag[0]` leaves `pend`=4'b0001.
6. Assert `sys_rst_n` low for 1 cycle during ON (timer=2): `act_out`=0, `busy`=0, `pend`=0 and `act_id`=0 immediately, and the block stays IDLE until the next flag.
